// File: rtl/csum_word_accumulator_if.sv
// Slice-in / word-out bus for the nibble-serial conditional-sum accumulator.
interface csum_word_accumulator_if #(
  parameter int NSLICES = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [9:0]             in_value;
  logic                   in_first;
  logic                   in_cin;
  logic                   out_valid;
  logic                   out_ready;
  logic [4*NSLICES-1:0]   out_sum;
  logic                   out_cout;
  logic                   err;

  modport master (
    output in_valid, in_value, in_first, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, err
  );

  modport slave (
    input  in_valid, in_value, in_first, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, err
  );
endinterface

// File: rtl/csum_word_accumulator.sv
// Resolves 10-bit conditional-sum slices LSB-first into a 4*NSLICES-bit word; out_valid 1 cycle after last slice.
// in_ready drops while a word is held; the word stays stable until out_ready, then one bubble before the next word.
module csum_word_accumulator #(
  parameter int NSLICES = 4,
  parameter int IDXW    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  csum_word_accumulator_if.slave bus
);
  localparam int W = 4 * NSLICES;

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t          state, state_d;
  logic [IDXW-1:0] idx, idx_d;
  logic            carry, carry_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            err_q, err_d;
  logic            ready, accept, as_first, c, nc, last;
  logic [3:0]      nib;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_d;
      idx    <= idx_d;
      carry  <= carry_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    state_d  = state;
    idx_d    = idx;
    carry_d  = carry;
    sum_d    = sum_q;
    cout_d   = cout_q;
    err_d    = 1'b0;
    ready    = (state != HOLD);
    accept   = bus.in_valid & ready;
    // In IDLE every beat starts a word; in ACC an in_first beat restarts it.
    as_first = (state == IDLE) | bus.in_first;
    c        = as_first ? bus.in_cin : carry;
    nib      = c ? bus.in_value[3:0] : bus.in_value[7:4];
    nc       = c ? bus.in_value[9] : bus.in_value[8];
    last     = as_first ? (NSLICES == 1) : (idx == IDXW'(NSLICES - 1));

    case (state)
      IDLE, ACC: begin
        if (accept) begin
          carry_d = nc;
          err_d   = (state == IDLE) ? ~bus.in_first : bus.in_first;
          for (int k = 0; k < NSLICES; k++) begin
            if (as_first)
              sum_d[4*k +: 4] = (k == 0) ? nib : 4'h0;
            else if (idx == IDXW'(k))
              sum_d[4*k +: 4] = nib;
          end
          if (last) begin
            state_d = HOLD;
            idx_d   = '0;
            cout_d  = nc;
          end else begin
            state_d = ACC;
            idx_d   = as_first ? IDXW'(1) : idx + IDXW'(1);
          end
        end
      end
      HOLD: begin
        if (bus.out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = (state == HOLD);
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_csum_word_accumulator.sv
// Directed bench for csum_word_accumulator (NSLICES=4) with hand-computed sums.
module tb_csum_word_accumulator;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   err_cnt;

  csum_word_accumulator_if #(.NSLICES(4)) bus ();

  csum_word_accumulator #(.NSLICES(4), .IDXW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // err is a one-cycle pulse, so each pulse is seen on exactly one falling edge.
  always @(negedge clk) if (bus.err === 1'b1) err_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [9:0] v, input logic f, input logic cin);
    bus.in_valid = 1'b1;
    bus.in_value = v;
    bus.in_first = f;
    bus.in_cin   = cin;
    step();
  endtask

  // Drives one full word; cin on later beats is inverted to show it is ignored.
  task automatic send4(input logic [9:0] v0, input logic [9:0] v1, input logic [9:0] v2,
                       input logic [9:0] v3, input logic cin, input logic f0);
    beat(v0, f0, cin);
    chk("mid_valid0", bus.out_valid, 0);
    beat(v1, 1'b0, ~cin);
    chk("mid_valid1", bus.out_valid, 0);
    beat(v2, 1'b0, ~cin);
    chk("mid_valid2", bus.out_valid, 0);
    beat(v3, 1'b0, ~cin);
    bus.in_valid = 1'b0;
    chk("word_valid", bus.out_valid, 1);
    chk("word_in_ready", bus.in_ready, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    err_cnt = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_value  = '0;
    bus.in_first  = 1'b0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b0;
    step();
    step();
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_sum", bus.out_sum, 32'h0);
    chk("rst_cout", bus.out_cout, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    rst_n = 1'b1;

    // 0xFFFF + 0x0001, cin=0
    err_cnt = 0;
    bus.out_ready = 1'b1;
    send4(10'h301, 10'h2F0, 10'h2F0, 10'h2F0, 1'b0, 1'b1);
    chk("ripple_sum", bus.out_sum, 32'h0000);
    chk("ripple_cout", bus.out_cout, 1);
    step();
    chk("ripple_drain_valid", bus.out_valid, 0);
    chk("ripple_drain_ready", bus.in_ready, 1);
    chk("ripple_keep_cout", bus.out_cout, 1);
    chk("ripple_err", err_cnt, 0);

    // 0x1234 + 0 + cin=1
    send4(10'h045, 10'h034, 10'h023, 10'h012, 1'b1, 1'b1);
    chk("cin_sum", bus.out_sum, 32'h1235);
    chk("cin_cout", bus.out_cout, 0);
    step();
    chk("cin_drain_valid", bus.out_valid, 0);

    // Backpressure: 0xFFFF + 0x0001 + 1 held for 3 cycles while next slice 0 waits
    bus.out_ready = 1'b0;
    send4(10'h301, 10'h2F0, 10'h2F0, 10'h2F0, 1'b1, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_value = 10'h045;
    bus.in_first = 1'b1;
    bus.in_cin   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_sum", bus.out_sum, 32'h0001);
      chk("bp_cout", bus.out_cout, 1);
    end
    bus.out_ready = 1'b1;
    step();
    chk("bp_release_valid", bus.out_valid, 0);
    chk("bp_release_ready", bus.in_ready, 1);
    chk("bp_release_sum", bus.out_sum, 32'h0001);
    send4(10'h045, 10'h034, 10'h023, 10'h012, 1'b1, 1'b1);
    chk("bp_next_sum", bus.out_sum, 32'h1235);
    chk("bp_next_cout", bus.out_cout, 0);
    step();

    // Restart mid-word: abandoned word yields nothing, new word is 0x000F
    err_cnt = 0;
    beat(10'h045, 1'b1, 1'b1);
    beat(10'h034, 1'b0, 1'b0);
    beat(10'h0F0, 1'b1, 1'b0);
    chk("rs_valid0", bus.out_valid, 0);
    beat(10'h000, 1'b0, 1'b1);
    chk("rs_valid1", bus.out_valid, 0);
    beat(10'h000, 1'b0, 1'b1);
    chk("rs_valid2", bus.out_valid, 0);
    beat(10'h000, 1'b0, 1'b1);
    bus.in_valid = 1'b0;
    chk("rs_valid", bus.out_valid, 1);
    chk("rs_sum", bus.out_sum, 32'h000F);
    chk("rs_cout", bus.out_cout, 0);
    step();
    chk("rs_err", err_cnt, 1);

    // Missing in_first on slice 0 from IDLE
    err_cnt = 0;
    send4(10'h045, 10'h034, 10'h023, 10'h012, 1'b1, 1'b0);
    chk("nf_sum", bus.out_sum, 32'h1235);
    chk("nf_cout", bus.out_cout, 0);
    step();
    chk("nf_err", err_cnt, 1);

    // Reset after two slices
    err_cnt = 0;
    beat(10'h045, 1'b1, 1'b1);
    beat(10'h034, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mr_valid", bus.out_valid, 0);
    chk("mr_sum", bus.out_sum, 32'h0);
    chk("mr_cout", bus.out_cout, 0);
    chk("mr_in_ready", bus.in_ready, 1);
    send4(10'h045, 10'h034, 10'h023, 10'h012, 1'b0, 1'b1);
    chk("mr_word_sum", bus.out_sum, 32'h1234);
    chk("mr_word_cout", bus.out_cout, 0);
    step();
    chk("mr_err", err_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
